// File: rtl/engine_arbiter.sv
// engine_arbiter: round-robin sharing of one handshake-driven compute engine among NREQ requesters.
// Define ENGINE_ARBITER_TIMEOUT_EN to enable the watchdog, the ABORT path, e_rst and u_err.
module engine_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW_IN   = 128,
  parameter int DW_OUT  = 256,
  parameter int TIMEOUT = 1048576
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        u_req_valid,
  output logic [NREQ-1:0]        u_req_ready,
  output logic [NREQ-1:0]        u_req_busy,
  output logic [NREQ-1:0]        u_res_valid,
  input  logic [NREQ-1:0]        u_res_ready,
  input  logic [NREQ*DW_IN-1:0]  u_in,
  output logic [DW_OUT-1:0]      u_out,
  output logic                   u_err,
  output logic [2:0]             grant,
  output logic                   e_req_valid,
  input  logic                   e_req_ready,
  input  logic                   e_req_busy,
  input  logic                   e_res_valid,
  output logic                   e_res_ready,
  output logic [DW_IN-1:0]       e_in,
  input  logic [DW_OUT-1:0]      e_out,
  output logic                   e_rst
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_DELIVER = 3'd3,
    S_RELEASE = 3'd4,
    S_ABORT   = 3'd5
  } state_t;

  state_t            r_state;
  logic [2:0]        r_ptr;
  logic [2:0]        r_grant;
  logic [NREQ-1:0]   r_req_ready;
  logic [NREQ-1:0]   r_req_busy;
  logic [NREQ-1:0]   r_res_valid;
  logic [DW_OUT-1:0] r_out;
  logic              r_e_req_valid;
  logic              r_e_res_ready;
  logic [DW_IN-1:0]  r_e_in;

  logic              w_any_req;
  logic [2:0]        w_pick;
  logic [3:0]        w_idx;
  logic [NREQ-1:0]   w_shift;
  logic [NREQ-1:0]   w_grant_oh;
  logic              w_release;
  logic [DW_IN-1:0]  w_operand;
  logic [2:0]        w_next_ptr;

`ifdef ENGINE_ARBITER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT);

  logic [WDW-1:0]    r_wd_cnt;
  logic              r_abort_ph;
  logic              r_aborted;
  logic              r_err;
  logic              r_e_rst;
  logic              w_wd_expire;

  // Saturating count keeps a late expiry (normal transition won the tie) aborting on the next cycle.
  assign w_wd_expire = (r_wd_cnt >= WDW'(TIMEOUT - 2));
`endif

  // First pending requester at or after ptr, wrapping modulo NREQ; lowest offset wins.
  always_comb begin
    w_any_req = 1'b0;
    w_pick    = 3'd0;
    w_idx     = 4'd0;
    w_shift   = {NREQ{1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + 4'(k);
      if (w_idx >= 4'(NREQ)) begin
        w_idx = w_idx - 4'(NREQ);
      end else begin
        w_idx = w_idx;
      end
      w_shift = u_req_valid >> w_idx;
      if (w_shift[0]) begin
        w_any_req = 1'b1;
        w_pick    = w_idx[2:0];
      end else begin
        w_any_req = w_any_req;
        w_pick    = w_pick;
      end
    end
  end

  assign w_grant_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_grant;
  assign w_release  = |(u_res_ready & w_grant_oh);
  assign w_operand  = DW_IN'(u_in >> (32'(w_pick) * 32'(DW_IN)));
  assign w_next_ptr = (r_grant == 3'(NREQ - 1)) ? 3'd0 : r_grant + 3'd1;

  // Arbitration/handshake state machine; every output is a register of this block.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_ptr         <= 3'd0;
      r_grant       <= 3'd0;
      r_req_ready   <= {NREQ{1'b0}};
      r_req_busy    <= {NREQ{1'b0}};
      r_res_valid   <= {NREQ{1'b0}};
      r_out         <= {DW_OUT{1'b0}};
      r_e_req_valid <= 1'b0;
      r_e_res_ready <= 1'b0;
      r_e_in        <= {DW_IN{1'b0}};
`ifdef ENGINE_ARBITER_TIMEOUT_EN
      r_wd_cnt      <= {WDW{1'b0}};
      r_abort_ph    <= 1'b0;
      r_aborted     <= 1'b0;
      r_err         <= 1'b0;
      r_e_rst       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant       <= w_pick;
            r_e_in        <= w_operand;
            r_e_req_valid <= 1'b1;
            r_state       <= S_ISSUE;
`ifdef ENGINE_ARBITER_TIMEOUT_EN
            r_wd_cnt      <= {WDW{1'b0}};
`endif
          end
        end
        S_ISSUE: begin
`ifdef ENGINE_ARBITER_TIMEOUT_EN
          if (r_wd_cnt != {WDW{1'b1}}) begin
            r_wd_cnt <= r_wd_cnt + WDW'(1);
          end
`endif
          if (e_req_ready) begin
            r_e_req_valid <= 1'b0;
            r_req_ready   <= w_grant_oh;
            r_req_busy    <= w_grant_oh;
            r_state       <= S_WAIT;
`ifdef ENGINE_ARBITER_TIMEOUT_EN
          end else if (w_wd_expire) begin
            // The requester still gets its acceptance pulse so it stops holding its operand.
            r_e_req_valid <= 1'b0;
            r_req_ready   <= w_grant_oh;
            r_req_busy    <= w_grant_oh;
            r_e_rst       <= 1'b1;
            r_abort_ph    <= 1'b0;
            r_aborted     <= 1'b1;
            r_state       <= S_ABORT;
`endif
          end
        end
        S_WAIT: begin
          r_req_ready <= {NREQ{1'b0}};
`ifdef ENGINE_ARBITER_TIMEOUT_EN
          if (r_wd_cnt != {WDW{1'b1}}) begin
            r_wd_cnt <= r_wd_cnt + WDW'(1);
          end
`endif
          if (e_res_valid) begin
            r_out       <= e_out;
            r_res_valid <= w_grant_oh;
            r_state     <= S_DELIVER;
`ifdef ENGINE_ARBITER_TIMEOUT_EN
            r_err       <= 1'b0;
          end else if (w_wd_expire) begin
            r_e_req_valid <= 1'b0;
            r_e_rst       <= 1'b1;
            r_abort_ph    <= 1'b0;
            r_aborted     <= 1'b1;
            r_state       <= S_ABORT;
`endif
          end
        end
        S_ABORT: begin
          r_req_ready <= {NREQ{1'b0}};
`ifdef ENGINE_ARBITER_TIMEOUT_EN
          if (!r_abort_ph) begin
            r_abort_ph <= 1'b1;
          end else begin
            r_e_rst     <= 1'b0;
            r_out       <= {DW_OUT{1'b0}};
            r_err       <= 1'b1;
            r_res_valid <= w_grant_oh;
            r_state     <= S_DELIVER;
          end
`else
          r_state <= S_IDLE;
`endif
        end
        S_DELIVER: begin
          if (w_release) begin
            r_res_valid   <= {NREQ{1'b0}};
            r_req_busy    <= {NREQ{1'b0}};
            r_state       <= S_RELEASE;
`ifdef ENGINE_ARBITER_TIMEOUT_EN
            r_e_res_ready <= ~r_aborted;
`else
            r_e_res_ready <= 1'b1;
`endif
          end
        end
        S_RELEASE: begin
          r_e_res_ready <= 1'b0;
          r_ptr         <= w_next_ptr;
          r_out         <= {DW_OUT{1'b0}};
          r_state       <= S_IDLE;
`ifdef ENGINE_ARBITER_TIMEOUT_EN
          r_aborted     <= 1'b0;
          r_err         <= 1'b0;
`endif
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign u_req_ready = r_req_ready;
  assign u_req_busy  = r_req_busy;
  assign u_res_valid = r_res_valid;
  assign u_out       = r_out;
  assign grant       = r_grant;
  assign e_req_valid = r_e_req_valid;
  assign e_res_ready = r_e_res_ready;
  assign e_in        = r_e_in;

`ifdef ENGINE_ARBITER_TIMEOUT_EN
  assign u_err = r_err;
  assign e_rst = r_e_rst;
`else
  assign u_err = 1'b0;
  assign e_rst = 1'b0;
`endif

endmodule

// File: tb/tb_engine_arbiter.sv
// Directed bench for engine_arbiter: single-request vector table plus multi-cycle arbitration,
// fairness, watchdog and mid-operation reset sequences against a small echoing engine model.
module tb_engine_arbiter;
  localparam int NREQ    = 4;
  localparam int DW_IN   = 128;
  localparam int DW_OUT  = 256;
  localparam int TIMEOUT = 16;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic [NREQ-1:0]       u_req_valid;
  logic [NREQ-1:0]       u_req_ready;
  logic [NREQ-1:0]       u_req_busy;
  logic [NREQ-1:0]       u_res_valid;
  logic [NREQ-1:0]       u_res_ready;
  logic [NREQ*DW_IN-1:0] u_in;
  logic [DW_OUT-1:0]     u_out;
  logic                  u_err;
  logic [2:0]            grant;
  logic                  e_req_valid;
  logic                  e_req_ready;
  logic                  e_req_busy;
  logic                  e_res_valid;
  logic                  e_res_ready;
  logic [DW_IN-1:0]      e_in;
  logic [DW_OUT-1:0]     e_out;
  logic                  e_rst;

  int total = 0;
  int bad   = 0;
  logic [NREQ-1:0] sticky = '0;

  logic             eng_busy;
  logic             eng_hang;
  int               eng_lat;
  int               eng_cnt;
  logic [DW_IN-1:0] eng_op;

  always #5 clk = ~clk;

  engine_arbiter #(.NREQ(NREQ), .DW_IN(DW_IN), .DW_OUT(DW_OUT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .u_req_valid(u_req_valid), .u_req_ready(u_req_ready), .u_req_busy(u_req_busy),
    .u_res_valid(u_res_valid), .u_res_ready(u_res_ready), .u_in(u_in),
    .u_out(u_out), .u_err(u_err), .grant(grant),
    .e_req_valid(e_req_valid), .e_req_ready(e_req_ready), .e_req_busy(e_req_busy),
    .e_res_valid(e_res_valid), .e_res_ready(e_res_ready),
    .e_in(e_in), .e_out(e_out), .e_rst(e_rst)
  );

  assign e_req_busy = eng_busy;

  // Engine model: accepts one operand, echoes it zero-extended after eng_lat cycles.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      e_req_ready <= 1'b0;
      e_res_valid <= 1'b0;
      e_out       <= '0;
      eng_busy    <= 1'b0;
      eng_cnt     <= 0;
      eng_op      <= '0;
    end else begin
      e_req_ready <= 1'b0;
      if (e_rst) begin
        eng_busy    <= 1'b0;
        e_res_valid <= 1'b0;
      end else if (!eng_busy) begin
        if (e_req_valid) begin
          e_req_ready <= 1'b1;
          eng_op      <= e_in;
          eng_busy    <= 1'b1;
          eng_cnt     <= eng_lat;
        end
      end else if (e_res_valid) begin
        if (e_res_ready) begin
          e_res_valid <= 1'b0;
          eng_busy    <= 1'b0;
        end
      end else if (!eng_hang) begin
        if (eng_cnt <= 1) begin
          e_res_valid <= 1'b1;
          e_out       <= DW_OUT'(eng_op);
        end else begin
          eng_cnt <= eng_cnt - 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [DW_OUT-1:0] act, input logic [DW_OUT-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Advance to the next falling edge; non-sticky requesters drop valid once accepted.
  task automatic step();
    @(negedge clk);
    u_req_valid = u_req_valid & ~(u_req_ready & ~sticky);
  endtask

  task automatic get_result(input int g, input logic [DW_OUT-1:0] exp_out, input logic exp_err);
    int n = 0;
    while (u_res_valid == '0 && n < 200) begin
      step();
      n++;
    end
    if (u_res_valid == '0) begin
      total++;
      bad++;
      $display("FAIL result_timeout: no u_res_valid after %0d cycles, want grant %0d", n, g);
    end else begin
      chk("res_grant", DW_OUT'(grant), DW_OUT'(g));
      chk("res_valid_onehot", DW_OUT'(u_res_valid), DW_OUT'(NREQ'(1) << g));
      chk("res_busy_onehot", DW_OUT'(u_req_busy), DW_OUT'(NREQ'(1) << g));
      chk("res_u_out", u_out, exp_out);
      chk("res_u_err", DW_OUT'(u_err), DW_OUT'(exp_err));
      u_res_ready = NREQ'(1) << g;
      step();
      u_res_ready = '0;
      chk("release_e_res_ready", DW_OUT'(e_res_ready), DW_OUT'(!exp_err));
      chk("release_res_valid", DW_OUT'(u_res_valid), '0);
      chk("release_busy", DW_OUT'(u_req_busy), '0);
    end
  endtask

  typedef struct {
    int                idx;
    logic [DW_IN-1:0]  op;
    int                lat;
    int                exp_grant;
    logic [DW_OUT-1:0] exp_out;
  } vec_t;

  vec_t             tbl[4];
  logic [DW_IN-1:0] ops4[4];
  logic [DW_IN-1:0] wd_op;
  int               n;

  initial begin
    tbl[0] = '{0, 128'h139871fcaa59a6eab6afb399292871e9, 10, 0, 256'h139871fcaa59a6eab6afb399292871e9};
    tbl[1] = '{3, 128'hffffffffffffffffffffffffffffffff, 1, 3, 256'hffffffffffffffffffffffffffffffff};
    tbl[2] = '{1, 128'h00000000000000000000000000000000, 3, 1, 256'h0};
    tbl[3] = '{2, 128'h80000000000000000000000000000001, 5, 2, 256'h80000000000000000000000000000001};
    ops4[0] = 128'h0123456789abcdef0000000000000a00;
    ops4[1] = 128'h1111111111111111000000000000b011;
    ops4[2] = 128'h2222222222222222000000000000c022;
    ops4[3] = 128'h3333333333333333000000000000d033;
    wd_op   = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

    u_req_valid = '0;
    u_res_ready = '0;
    u_in        = '0;
    eng_hang    = 1'b0;
    eng_lat     = 4;
    rstn        = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_u_req_ready", DW_OUT'(u_req_ready), '0);
    chk("rst_u_req_busy", DW_OUT'(u_req_busy), '0);
    chk("rst_u_res_valid", DW_OUT'(u_res_valid), '0);
    chk("rst_u_out", u_out, '0);
    chk("rst_u_err", DW_OUT'(u_err), '0);
    chk("rst_grant", DW_OUT'(grant), '0);
    chk("rst_e_req_valid", DW_OUT'(e_req_valid), '0);
    chk("rst_e_res_ready", DW_OUT'(e_res_ready), '0);
    chk("rst_e_in", DW_OUT'(e_in), '0);
    chk("rst_e_rst", DW_OUT'(e_rst), '0);
    rstn = 1'b1;
    step();

    for (int v = 0; v < 4; v++) begin
      eng_lat = tbl[v].lat;
      u_in[tbl[v].idx*DW_IN +: DW_IN] = tbl[v].op;
      u_req_valid = u_req_valid | (NREQ'(1) << tbl[v].idx);
      step();
      chk("vec_e_req_valid", DW_OUT'(e_req_valid), DW_OUT'(1));
      chk("vec_e_in", DW_OUT'(e_in), DW_OUT'(tbl[v].op));
      chk("vec_grant", DW_OUT'(grant), DW_OUT'(tbl[v].exp_grant));
      step();
      step();
      chk("vec_u_req_ready", DW_OUT'(u_req_ready), DW_OUT'(NREQ'(1) << tbl[v].exp_grant));
      step();
      chk("vec_u_req_ready_end", DW_OUT'(u_req_ready), '0);
      get_result(tbl[v].exp_grant, tbl[v].exp_out, 1'b0);
      step();
      chk("vec_e_res_ready_end", DW_OUT'(e_res_ready), '0);
    end

    // All four requesters together from reset: grants 0,1,2,3 with minimum turnaround.
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    eng_lat = 2;
    for (int i = 0; i < NREQ; i++) u_in[i*DW_IN +: DW_IN] = ops4[i];
    u_req_valid = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      get_result(k, DW_OUT'(ops4[k]), 1'b0);
      if (k < NREQ - 1) begin
        step();
        step();
        chk("turnaround_e_req_valid", DW_OUT'(e_req_valid), DW_OUT'(1));
        chk("turnaround_grant", DW_OUT'(grant), DW_OUT'(k + 1));
      end
    end

    // Fairness: 0 and 2 continuously valid, 1 raised mid-sequence.
    sticky = 4'b0101;
    u_req_valid = 4'b0101;
    get_result(0, DW_OUT'(ops4[0]), 1'b0);
    get_result(2, DW_OUT'(ops4[2]), 1'b0);
    u_req_valid = u_req_valid | 4'b0010;
    get_result(0, DW_OUT'(ops4[0]), 1'b0);
    get_result(1, DW_OUT'(ops4[1]), 1'b0);
    get_result(2, DW_OUT'(ops4[2]), 1'b0);
    step();
    step();
    chk("fair_last_grant", DW_OUT'(grant), DW_OUT'(0));
    sticky = '0;
    u_req_valid = '0;
    get_result(0, DW_OUT'(ops4[0]), 1'b0);
    step();
    step();
    chk("idle_no_request", DW_OUT'(e_req_valid), '0);

    // Engine accepts but never answers.
    eng_hang = 1'b1;
    u_in[1*DW_IN +: DW_IN] = wd_op;
    u_req_valid = 4'b0010;
    step();
    chk("wd_issue_entry", DW_OUT'(e_req_valid), DW_OUT'(1));
    n = 0;
    while (!e_rst && n < 40) begin
      step();
      n++;
    end
`ifdef ENGINE_ARBITER_TIMEOUT_EN
    chk("wd_abort_cycles", DW_OUT'(n), DW_OUT'(15));
    step();
    chk("wd_e_rst_2nd", DW_OUT'(e_rst), DW_OUT'(1));
    chk("wd_e_req_valid", DW_OUT'(e_req_valid), '0);
    step();
    chk("wd_e_rst_off", DW_OUT'(e_rst), '0);
    eng_hang = 1'b0;
    get_result(1, '0, 1'b1);
`else
    chk("wd_no_abort", DW_OUT'(n), DW_OUT'(40));
    chk("wd_no_result", DW_OUT'(u_res_valid), '0);
    eng_hang = 1'b0;
    get_result(1, DW_OUT'(wd_op), 1'b0);
`endif

    // Reset pulsed while requester 2 waits on a slow engine.
    eng_lat = 20;
    u_in[2*DW_IN +: DW_IN] = 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a;
    u_req_valid = 4'b0100;
    n = 0;
    while (u_req_busy == '0 && n < 20) begin
      step();
      n++;
    end
    chk("rstw_busy_seen", DW_OUT'(u_req_busy), DW_OUT'(4'b0100));
    step();
    rstn = 1'b0;
    #1;
    chk("rstw_busy", DW_OUT'(u_req_busy), '0);
    chk("rstw_grant", DW_OUT'(grant), '0);
    chk("rstw_e_req_valid", DW_OUT'(e_req_valid), '0);
    chk("rstw_res_valid", DW_OUT'(u_res_valid), '0);
    chk("rstw_e_in", DW_OUT'(e_in), '0);
    step();
    rstn = 1'b1;
    eng_lat = 2;
    u_in[1*DW_IN +: DW_IN] = 128'h000000000000000000000000000000c1;
    u_in[3*DW_IN +: DW_IN] = 128'h000000000000000000000000000000c3;
    u_req_valid = 4'b1010;
    step();
    chk("rstw_new_grant", DW_OUT'(grant), DW_OUT'(1));
    get_result(1, 256'hc1, 1'b0);
    get_result(3, 256'hc3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
